// File: rtl/ag32gbd_reg_responder.sv
`default_nettype none
// ============================================================================
//  Module   : ag32gbd_reg_responder
//  Purpose  : 4-phase register-read responder over a 1024x8 threshold memory,
//             with a one-entry host write buffer.
//             Optional macro AG32_REG_RESP_RANGE_CHECK_EN limits accesses to
//             the dither window 0x200-0x22F.
//  Revision : 1.0 - initial release
// ============================================================================
module ag32gbd_reg_responder #(
  parameter int READ_LATENCY = 2
) (
  input  logic       sys_clock,
  input  logic       sys_resetn,
  input  logic       RequestReadReg,
  input  logic [9:0] RegReadAddr,
  output logic [7:0] RegReadOutput,
  output logic       RegReadDone,
  input  logic       HostWrite,
  input  logic [9:0] HostWriteAddr,
  input  logic [7:0] HostWriteData,
  output logic       HostWriteBusy,
  output logic       WriteOverflow
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] c_LATENCY = 3'(READ_LATENCY);

  logic [7:0] r_mem [1024];
  logic [7:0] r_pipe [READ_LATENCY];

  state_t     r_state;
  logic [2:0] r_count;
  logic [9:0] r_readAddr;
  logic       r_readInRange;
  logic       r_readPending;
  logic [9:0] r_wbufAddr;
  logic [7:0] r_wbufData;

  logic       w_readInRange;
  logic       w_writeInRange;
  logic       w_memWrite;

`ifdef AG32_REG_RESP_RANGE_CHECK_EN
  assign w_readInRange  = (RegReadAddr >= 10'h200) && (RegReadAddr <= 10'h22F);
  assign w_writeInRange = (r_wbufAddr  >= 10'h200) && (r_wbufAddr  <= 10'h22F);
`else
  assign w_readInRange  = 1'b1;
  assign w_writeInRange = 1'b1;
`endif

  assign w_memWrite = (r_state == S_WRITE) && w_writeInRange;

  // Memory and read pipeline are not reset; contents survive sys_resetn.
  always_ff @(posedge sys_clock) begin
    if (w_memWrite) begin
      r_mem[r_wbufAddr] <= r_wbufData;
    end
    r_pipe[0] <= r_mem[r_readAddr];
    for (int i = 1; i < READ_LATENCY; i++) begin
      r_pipe[i] <= r_pipe[i-1];
    end
  end

  always_ff @(posedge sys_clock or negedge sys_resetn) begin
    if (!sys_resetn) begin
      r_state       <= S_IDLE;
      r_count       <= 3'd0;
      r_readAddr    <= 10'd0;
      r_readInRange <= 1'b0;
      r_readPending <= 1'b0;
      r_wbufAddr    <= 10'd0;
      r_wbufData    <= 8'd0;
      RegReadOutput <= 8'h00;
      RegReadDone   <= 1'b0;
      HostWriteBusy <= 1'b0;
      WriteOverflow <= 1'b0;
    end else begin
      if (HostWrite) begin
        if (HostWriteBusy) begin
          WriteOverflow <= 1'b1;
        end else begin
          r_wbufAddr    <= HostWriteAddr;
          r_wbufData    <= HostWriteData;
          HostWriteBusy <= 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (HostWriteBusy) begin
            r_state <= S_WRITE;
          end else if (RequestReadReg && !RegReadDone) begin
            r_readAddr    <= RegReadAddr;
            r_readInRange <= w_readInRange;
            r_count       <= c_LATENCY;
            // A strobe arriving with the request is committed before the read.
            if (HostWrite) begin
              r_readPending <= 1'b1;
              r_state       <= S_WRITE;
            end else begin
              r_state       <= S_READ;
            end
          end
        end
        S_WRITE: begin
          HostWriteBusy <= 1'b0;
          r_readPending <= 1'b0;
          r_state       <= r_readPending ? S_READ : S_IDLE;
        end
        S_READ: begin
          if (r_count == 3'd0) begin
            RegReadOutput <= r_readInRange ? r_pipe[READ_LATENCY-1] : 8'hFF;
            RegReadDone   <= 1'b1;
            r_state       <= S_DONE;
          end else begin
            r_count <= r_count - 3'd1;
          end
        end
        S_DONE: begin
          if (!RequestReadReg) begin
            RegReadDone <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ag32gbd_reg_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ag32gbd_reg_responder
//  Purpose  : Scoreboard bench for ag32gbd_reg_responder (READ_LATENCY = 2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ag32gbd_reg_responder;

  localparam int c_LAT = 2;

  logic       sys_clock = 1'b0;
  logic       sys_resetn = 1'b0;
  logic       RequestReadReg = 1'b0;
  logic [9:0] RegReadAddr = 10'd0;
  logic [7:0] RegReadOutput;
  logic       RegReadDone;
  logic       HostWrite = 1'b0;
  logic [9:0] HostWriteAddr = 10'd0;
  logic [7:0] HostWriteData = 8'd0;
  logic       HostWriteBusy;
  logic       WriteOverflow;

  ag32gbd_reg_responder #(.READ_LATENCY(c_LAT)) dut (
    .sys_clock      (sys_clock),
    .sys_resetn     (sys_resetn),
    .RequestReadReg (RequestReadReg),
    .RegReadAddr    (RegReadAddr),
    .RegReadOutput  (RegReadOutput),
    .RegReadDone    (RegReadDone),
    .HostWrite      (HostWrite),
    .HostWriteAddr  (HostWriteAddr),
    .HostWriteData  (HostWriteData),
    .HostWriteBusy  (HostWriteBusy),
    .WriteOverflow  (WriteOverflow)
  );

  always #5 sys_clock = ~sys_clock;

  int cyc = 0;
  always @(posedge sys_clock) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         doneCyc;
  } exp_t;

  exp_t sbq[$];
  exp_t monE;
  int   nCompared = 0;
  int   nMismatch = 0;
  logic prevDone = 1'b0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatch++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: every rising Done is matched against the oldest expected read.
  always @(negedge sys_clock) begin
    if (RegReadDone === 1'b1 && prevDone !== 1'b1) begin
      if (sbq.size() == 0) begin
        nCompared++;
        nMismatch++;
        $display("FAIL unexpected_done: got data 0x%0h at cycle %0d, expected no Done", RegReadOutput, cyc);
      end else begin
        monE = sbq.pop_front();
        check("read_data", 32'(RegReadOutput), 32'(monE.data));
        check("done_cycle", cyc, monE.doneCyc);
      end
    end
    prevDone = RegReadDone;
  end

  task automatic tick();
    @(posedge sys_clock);
    #1;
  endtask

  task automatic hostWr(input logic [9:0] addr, input logic [7:0] data);
    HostWriteAddr = addr;
    HostWriteData = data;
    HostWrite     = 1'b1;
    tick();
    HostWrite     = 1'b0;
  endtask

  task automatic issueRead(input logic [9:0] addr, input logic [7:0] expData, input int extra);
    RequestReadReg = 1'b1;
    RegReadAddr    = addr;
    sbq.push_back('{expData, cyc + 1 + c_LAT + 1 + extra});
  endtask

  task automatic finishRead();
    bit got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (RegReadDone) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    if (!got) begin
      nCompared++;
      nMismatch++;
      $display("FAIL done_timeout: got Done=0 after 20 cycles, expected Done=1");
    end
    tick();
    check("done_held", 32'(RegReadDone), 32'd1);
    RequestReadReg = 1'b0;
    tick();
    check("done_fall", 32'(RegReadDone), 32'd0);
  endtask

  task automatic doRead(input logic [9:0] addr, input logic [7:0] expData, input int extra,
                        input bit wr, input logic [9:0] wAddr, input logic [7:0] wData);
    issueRead(addr, expData, extra);
    if (wr) begin
      HostWriteAddr = wAddr;
      HostWriteData = wData;
      HostWrite     = 1'b1;
    end
    tick();
    HostWrite = 1'b0;
    finishRead();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected finish before 100000 ns");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge sys_clock);
    #1;
    check("rst_output", 32'(RegReadOutput), 32'h00);
    check("rst_done", 32'(RegReadDone), 32'd0);
    check("rst_busy", 32'(HostWriteBusy), 32'd0);
    check("rst_overflow", 32'(WriteOverflow), 32'd0);
    sys_resetn = 1'b1;
    tick();

    // Single write then read of the same location.
    hostWr(10'h205, 8'h5A);
    check("busy_set", 32'(HostWriteBusy), 32'd1);
    tick();
    check("busy_hold", 32'(HostWriteBusy), 32'd1);
    tick();
    check("busy_clear", 32'(HostWriteBusy), 32'd0);
    doRead(10'h205, 8'h5A, 0, 1'b0, 10'd0, 8'd0);

    hostWr(10'h200, 8'hA0); repeat (2) tick();
    hostWr(10'h201, 8'hA1); repeat (2) tick();
    hostWr(10'h202, 8'hA2); repeat (2) tick();
    hostWr(10'h210, 8'h11); repeat (2) tick();
    hostWr(10'h220, 8'h10); repeat (2) tick();
    hostWr(10'h22A, 8'h5C); repeat (2) tick();
    hostWr(10'h22F, 8'h7E); repeat (2) tick();

    // Sampler pattern: request dropped for exactly one cycle between reads.
    doRead(10'h200, 8'hA0, 0, 1'b0, 10'd0, 8'd0);
    doRead(10'h201, 8'hA1, 0, 1'b0, 10'd0, 8'd0);
    doRead(10'h202, 8'hA2, 0, 1'b0, 10'd0, 8'd0);
    doRead(10'h22F, 8'h7E, 0, 1'b0, 10'd0, 8'd0);

    // Write and request in the same cycle: write wins, one extra cycle.
    doRead(10'h210, 8'h22, 1, 1'b1, 10'h210, 8'h22);
    check("busy_after_coincident", 32'(HostWriteBusy), 32'd0);

    // Two strobes back to back during a read: second one is dropped.
    issueRead(10'h220, 8'h10, 0);
    tick();
    HostWriteAddr = 10'h220;
    HostWriteData = 8'h99;
    HostWrite     = 1'b1;
    tick();
    check("ovf_busy", 32'(HostWriteBusy), 32'd1);
    check("ovf_not_yet", 32'(WriteOverflow), 32'd0);
    HostWriteData = 8'hEE;
    tick();
    HostWrite = 1'b0;
    check("ovf_set", 32'(WriteOverflow), 32'd1);
    finishRead();
    repeat (3) tick();
    check("ovf_sticky", 32'(WriteOverflow), 32'd1);
    check("ovf_busy_clear", 32'(HostWriteBusy), 32'd0);
    doRead(10'h220, 8'h99, 0, 1'b0, 10'd0, 8'd0);

    // Reset in the middle of a read.
    RequestReadReg = 1'b1;
    RegReadAddr    = 10'h22A;
    tick();
    tick();
    sys_resetn = 1'b0;
    #1;
    check("midrst_done", 32'(RegReadDone), 32'd0);
    check("midrst_output", 32'(RegReadOutput), 32'h00);
    check("midrst_overflow", 32'(WriteOverflow), 32'd0);
    RequestReadReg = 1'b0;
    tick();
    sys_resetn = 1'b1;
    tick();
    doRead(10'h22A, 8'h5C, 0, 1'b0, 10'd0, 8'd0);

`ifdef AG32_REG_RESP_RANGE_CHECK_EN
    doRead(10'h230, 8'hFF, 0, 1'b0, 10'd0, 8'd0);
    hostWr(10'h100, 8'h33);
    repeat (3) tick();
    doRead(10'h100, 8'hFF, 0, 1'b0, 10'd0, 8'd0);
`else
    hostWr(10'h100, 8'h33);
    repeat (3) tick();
    doRead(10'h100, 8'h33, 0, 1'b0, 10'd0, 8'd0);
`endif

    repeat (5) tick();
    check("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ag32gbd_reg_responder.md
# ag32gbd_reg_responder

Responder side of the sampler's 4-phase register-read handshake. It serves `RequestReadReg`/`RegReadAddr` from an internal 1024×8 threshold memory and returns `RegReadOutput` with `RegReadDone`. A host write port loads the memory; the dither thresholds live at 0x200–0x22F. The block sits between the host register bridge and the pixel sampler, all on `sys_clock`.

## Interface
- `READ_LATENCY`, 2, cycles from memory address register to data valid; legal range 1–4.
- `sys_clock`  in  1  system clock, 100 MHz.
- `sys_resetn`  in  1  reset; asynchronous assert, active-low.
- `RequestReadReg`  in  1  read request level from the sampler.
- `RegReadAddr`  in  10  read address; valid while the request is high.
- `RegReadOutput`  out  8  read data; stable whenever `RegReadDone` is high.
- `RegReadDone`  out  1  read acknowledge level.
- `HostWrite`  in  1  single-cycle write strobe.
- `HostWriteAddr`  in  10  write address, qualified by `HostWrite`.
- `HostWriteData`  in  8  write data, qualified by `HostWrite`.
- `HostWriteBusy`  out  1  write buffer occupied.
- `WriteOverflow`  out  1  sticky flag: a strobe arrived while busy; the new write is dropped.

## Operation
- Reset values: `RegReadOutput`=0x00, `RegReadDone`=0, `HostWriteBusy`=0, `WriteOverflow`=0, state S_IDLE. Memory contents are not reset.
- Write buffer (one entry):
  - On `HostWrite` with the buffer empty, capture addr/data and set busy on the next edge.
  - On `HostWrite` with the buffer busy, drop the strobe and set `WriteOverflow`. It clears only on reset.
- S_IDLE:
  - Buffer busy: go to S_WRITE. A pending write beats a new read.
  - Else, `RequestReadReg`=1 and `RegReadDone`=0: latch `RegReadAddr`, load the pipeline counter with `READ_LATENCY`, go to S_READ.
- S_WRITE: write memory at the buffered address, clear busy, return to S_IDLE. One cycle.
- S_READ:
  - Decrement the counter each cycle.
  - When the counter reaches 0, capture the pipeline output into `RegReadOutput`, set `RegReadDone`=1, go to S_DONE.
- S_DONE:
  - Hold `RegReadDone`=1 while `RequestReadReg`=1.
  - On the first cycle the request is seen low, clear `RegReadDone` on the next edge and go to S_IDLE. The request only needs to be low for exactly 1 cycle; the sampler drops it for one cycle only.
- `RegReadOutput` keeps its last value after Done falls, until the next Done.
- Request dropped in S_READ (protocol violation): finish the read, assert Done, then complete S_DONE normally.
- Address changes while a read is in flight are ignored; the address is latched at accept.
- Read-after-write to the same address returns the new data, because the write completes in S_WRITE before the read is accepted.

## Timing
- Read accepted at edge k (S_IDLE sees the request): `RegReadDone` rises at edge k+`READ_LATENCY`+1. With the default this is 3 cycles; it is never earlier than k+2.
- Request seen low at edge m: Done low at edge m+1. A re-raised request is accepted at the earliest at edge m+2.
- A pending write adds exactly 1 cycle to a read accepted in the same S_IDLE cycle.
- Write strobe at edge w: `HostWriteBusy` high from w+1. Busy clears 1 edge after S_WRITE, which is at the earliest w+2 when idle.
- A write arriving during S_READ or S_DONE waits until the next S_IDLE.
- Reset mid-read: all outputs return to their reset values immediately. The in-flight read and any buffered write are discarded.

## Configuration
- Macro: `AG32_REG_RESP_RANGE_CHECK_EN`.
- Defined:
  - Valid addresses are 0x200–0x22F (48 entries).
  - A read outside that range returns 0xFF with identical Done timing and does not access memory.
  - A write outside that range is accepted into the buffer (busy timing unchanged) but discarded in S_WRITE.
- Undefined: all 1024 addresses are readable and writable.

## Test plan
- Write 0x5A to 0x205, then read 0x205 → Done at k+3 (`READ_LATENCY`=2), data 0x5A, Done held until the request falls, then low 1 cycle later.
- Back-to-back sampler pattern: reads of 0x200/0x201/0x202 with the request low 1 cycle between them → three Done pulses, data in order, no missed requests.
- `HostWrite` and a request in the same cycle, same address 0x210 (old 0x11, new 0x22) → write first, read returns 0x22, Done at k+4.
- Two `HostWrite` strobes 1 cycle apart while a read is in flight → first write kept, second dropped, `WriteOverflow`=1 and sticky.
- Reset asserted during S_READ → Done=0 and output=0x00 immediately. After release a new read of a previously written address returns the correct data.
- With `AG32_REG_RESP_RANGE_CHECK_EN` defined, read 0x230 → 0xFF at k+3. Write 0x100=0x33 → not stored.
